// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the two-requester memory arbiter.
//   - arb_state_e : arbiter ownership state (IDLE=0, OWN0=1, OWN1=2)
//   - MAX_BURST_DEF : default burst length before a forced hand-over
//   - CNT_W : width of the burst counter (MAX_BURST must fit, range 1..15)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam int unsigned MAX_BURST_DEF = 4;
  localparam int unsigned CNT_W         = 4;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates two requesters onto one single-cycle memory port.
//
// Build option: define MEM_ARB_RR_EN for round-robin resolution of
// simultaneous requests; otherwise requester 0 has fixed priority.
//
// Parameters:
//   MAX_BURST  consecutive granted cycles before a forced hand-over (1..15)
//   AW         address width (data width is fixed at 32)
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   req0/req1             access request, held until the requester is done
//   addr0/addr1           requester addresses
//   wdata0/wdata1         requester write data
//   we0/we1               1 = write, 0 = read
//   gnt0/gnt1             ownership, decoded from the registered state
//   ack0/ack1             access accepted this cycle
//   rdata                 read data shared by both requesters
//   rvalid0/rvalid1       rdata valid for that requester
//   mem_addr/mem_data/mem_we  shared memory port
//   mem_rdata             memory read data, valid one cycle after the address
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = MAX_BURST_DEF,
  parameter int unsigned AW        = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [31:0]   wdata0,
  input  logic [31:0]   wdata1,
  input  logic          we0,
  input  logic          we1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          ack0,
  output logic          ack1,
  output logic [31:0]   rdata,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_data,
  output logic          mem_we,
  input  logic [31:0]   mem_rdata
);

  localparam logic [CNT_W-1:0] BURST_MAX = MAX_BURST[CNT_W-1:0];

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_sat;
  logic [1:0]       rd_pend_q, rd_pend_d;
  logic [31:0]      rdata_q;
  logic             tie_to_1;

  assign gnt0 = (state_q == OWN0);
  assign gnt1 = (state_q == OWN1);
  assign ack0 = gnt0 & req0;
  assign ack1 = gnt1 & req1;

`ifdef MEM_ARB_RR_EN
  // rr_q holds the requester favoured on the next tie; it is the opposite
  // of the last owner, so reset value 0 lets requester 0 win first.
  logic rr_q, rr_d;
  assign tie_to_1 = rr_q;

  always_comb begin
    rr_d = rr_q;
    if (state_d == OWN0 && state_q != OWN0) rr_d = 1'b1;
    if (state_d == OWN1 && state_q != OWN1) rr_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_q <= 1'b0;
    else     rr_q <= rr_d;
  end
`else
  assign tie_to_1 = 1'b0;
`endif

  // Shared memory port: only an accepted access drives it, so a release
  // cycle (grant still high, request already low) leaves the port quiet.
  always_comb begin
    mem_addr = '0;
    mem_data = '0;
    mem_we   = 1'b0;
    if (ack0) begin
      mem_addr = addr0;
      mem_data = wdata0;
      mem_we   = we0;
    end else if (ack1) begin
      mem_addr = addr1;
      mem_data = wdata1;
      mem_we   = we1;
    end
  end

  // Counter value including this cycle's ack; the hand-over decision uses
  // it so the owner gets exactly MAX_BURST acks before yielding.
  always_comb begin
    cnt_sat = cnt_q;
    if ((ack0 | ack1) && (cnt_q != BURST_MAX)) cnt_sat = cnt_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1) state_d = tie_to_1 ? OWN1 : OWN0;
        else if (req0)    state_d = OWN0;
        else if (req1)    state_d = OWN1;
      end
      OWN0: begin
        if (!req0)                             state_d = req1 ? OWN1 : IDLE;
        else if (cnt_sat == BURST_MAX && req1) state_d = OWN1;
      end
      OWN1: begin
        if (!req1)                             state_d = req0 ? OWN0 : IDLE;
        else if (cnt_sat == BURST_MAX && req0) state_d = OWN0;
      end
      default: state_d = IDLE;
    endcase
    cnt_d = (state_d != state_q) ? '0 : cnt_sat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Read return: the memory answers one cycle after the address, so the
  // pending flag lines up with mem_rdata; rdata_q keeps the last value.
  assign rd_pend_d = {ack1 & ~we1, ack0 & ~we0};
  assign rvalid0   = rd_pend_q[0];
  assign rvalid1   = rd_pend_q[1];
  assign rdata     = (|rd_pend_q) ? mem_rdata : rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend_q <= '0;
      rdata_q   <= '0;
    end else begin
      rd_pend_q <= rd_pend_d;
      rdata_q   <= rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int MAXB = 4;
  localparam int AW   = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [31:0]   wdata0, wdata1;
  logic          gnt0, gnt1, ack0, ack1, rvalid0, rvalid1, mem_we;
  logic [31:0]   rdata, mem_data, mem_rdata;
  logic [AW-1:0] mem_addr;

  logic [31:0]   mem [0:15];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_BURST(MAXB), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .we0(we0), .we1(we1),
    .gnt0(gnt0), .gnt1(gnt1),
    .ack0(ack0), .ack1(ack1),
    .rdata(rdata),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  // Environment memory: synchronous read, one-cycle latency.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 + i;
      mem_rdata <= 32'h0;
    end else begin
      mem_rdata <= mem[mem_addr[5:2]];
      if (mem_we) mem[mem_addr[5:2]] <= mem_data;
    end
  end

  // Reference model: owner as an integer (-1 = none), burst count, and the
  // memory contents as the arbiter's accesses should have left them.
  int          m_own;
  int          m_burst;
  int          m_pend;
  logic [31:0] m_pdata;
  logic [31:0] m_hold;
  logic [31:0] ref_mem [0:15];
`ifdef MEM_ARB_RR_EN
  int          m_prio;
`endif

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic rq(input int x);
    return (x == 0) ? req0 : req1;
  endfunction

  function automatic int acked();
    if (m_own == 0 && req0) return 0;
    if (m_own == 1 && req1) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_own = -1; m_burst = 0; m_pend = -1; m_pdata = 0; m_hold = 0;
`ifdef MEM_ARB_RR_EN
    m_prio = 0;
`endif
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h1000_0000 + i;
  endtask

  task automatic check_outputs();
    int a;
    logic [64:0] exp_mem;
    a = acked();
    exp_mem = '0;
    if (a == 0) exp_mem = {we0, addr0, wdata0};
    if (a == 1) exp_mem = {we1, addr1, wdata1};
    check_eq("gnt", {62'd0, gnt1, gnt0}, {62'd0, m_own == 1, m_own == 0});
    check_eq("ack", {62'd0, ack1, ack0}, {62'd0, a == 1, a == 0});
    check_eq("mem_port", {mem_addr, mem_data}, exp_mem[63:0]);
    check_eq("mem_we", {63'd0, mem_we}, {63'd0, exp_mem[64]});
    check_eq("rvalid", {62'd0, rvalid1, rvalid0}, {62'd0, m_pend == 1, m_pend == 0});
    check_eq("rdata", {32'd0, rdata}, {32'd0, (m_pend >= 0) ? m_pdata : m_hold});
  endtask

  // Advance the model across one rising edge, using the inputs held there.
  task automatic model_edge();
    int a, nxt, o, tie;
    logic [3:0] idx;
    a = acked();
    if (m_pend >= 0) m_hold = m_pdata;
    m_pend = -1;
    if (a >= 0) begin
      idx = (a == 0) ? addr0[5:2] : addr1[5:2];
      if (((a == 0) ? we0 : we1) == 1'b0) begin
        m_pend  = a;
        m_pdata = ref_mem[idx];
      end else begin
        ref_mem[idx] = (a == 0) ? wdata0 : wdata1;
      end
    end
`ifdef MEM_ARB_RR_EN
    tie = m_prio;
`else
    tie = 0;
`endif
    if (m_own < 0) begin
      if (req0 && req1) nxt = tie;
      else if (req0)    nxt = 0;
      else if (req1)    nxt = 1;
      else              nxt = -1;
    end else begin
      o = m_own;
      if (!rq(o))                                         nxt = rq(1 - o) ? 1 - o : -1;
      else if ((m_burst + 1 >= MAXB) && rq(1 - o))        nxt = 1 - o;
      else                                                nxt = o;
    end
    if (nxt != m_own) begin
      m_burst = 0;
`ifdef MEM_ARB_RR_EN
      if (nxt >= 0) m_prio = 1 - nxt;
`endif
    end else if (a >= 0) begin
      m_burst = (m_burst + 1 > MAXB) ? MAXB : m_burst + 1;
    end
    m_own = nxt;
  endtask

  task automatic step(input logic r0, input logic r1, input logic w0, input logic w1,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1);
    req0 = r0; req1 = r1; we0 = w0; we1 = w1;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    rst = 1'b1;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int n_ack0, first_g1, exp_w;
    logic r0, r1;

    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    rst = 1'b1;
    model_reset();
    #12;
    check_outputs();
    @(posedge clk); #1;
    rst = 1'b0;

    // Single write from requester 0.
    step(1, 0, 1, 0, 32'h10, 0, 32'hABCD, 0);
    check_eq("wr_gnt0", {63'd0, gnt0}, 64'd1);
    check_eq("wr_ack0", {63'd0, ack0}, 64'd1);
    check_eq("wr_mem_addr", {32'd0, mem_addr}, 64'h10);
    check_eq("wr_mem_data", {32'd0, mem_data}, 64'hABCD);
    check_eq("wr_mem_we", {63'd0, mem_we}, 64'd1);
    step(1, 0, 1, 0, 32'h10, 0, 32'hABCD, 0);
    // Release with the other requester idle.
    req0 = 0;
    #1;
    check_eq("rel_gnt0", {63'd0, gnt0}, 64'd1);
    check_eq("rel_ack0", {63'd0, ack0}, 64'd0);
    check_eq("rel_mem_we", {63'd0, mem_we}, 64'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("rel_idle_gnt", {62'd0, gnt1, gnt0}, 64'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Requester 1 writes 0x1234 to 0x4, then reads it back.
    step(0, 1, 0, 1, 0, 32'h4, 0, 32'h1234);
    step(0, 1, 0, 1, 0, 32'h4, 0, 32'h1234);
    step(0, 1, 0, 0, 0, 32'h4, 0, 0);
    check_eq("rd_rvalid1", {63'd0, rvalid1}, 64'd1);
    check_eq("rd_rvalid0", {63'd0, rvalid0}, 64'd0);
    check_eq("rd_rdata", {32'd0, rdata}, 64'h1234);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset mid-grant with a read in flight.
    step(1, 0, 0, 0, 32'h8, 0, 0, 0);
    step(1, 0, 0, 0, 32'h8, 0, 0, 0);
    check_eq("mid_rvalid0", {63'd0, rvalid0}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_gnt", {62'd0, gnt1, gnt0}, 64'd0);
    check_eq("rst_ack", {62'd0, ack1, ack0}, 64'd0);
    check_eq("rst_mem", {31'd0, mem_we, mem_addr}, 64'd0);
    check_eq("rst_mem_data", {32'd0, mem_data}, 64'd0);
    check_eq("rst_rvalid", {62'd0, rvalid1, rvalid0}, 64'd0);
    check_eq("rst_rdata", {32'd0, rdata}, 64'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_eq("post_rst_gnt", {62'd0, gnt1, gnt0}, 64'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Simultaneous requests: first and second decisions.
    do_reset();
    step(1, 1, 0, 0, 32'h20, 32'h24, 0, 0);
    check_eq("tie1_gnt0", {63'd0, gnt0}, 64'd1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 32'h20, 32'h24, 0, 0);
`ifdef MEM_ARB_RR_EN
    exp_w = 1;
`else
    exp_w = 0;
`endif
    check_eq("tie2_winner", {62'd0, gnt1, gnt0}, (exp_w == 1) ? 64'd2 : 64'd1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Burst limit: both held, requester 0 gets MAXB acks then hands over.
    do_reset();
    step(1, 1, 1, 1, 32'h30, 32'h34, 32'h5, 32'h6);
    n_ack0 = 0;
    first_g1 = -1;
    for (int i = 0; i < 8; i++) begin
      if (ack0) n_ack0++;
      if (gnt1 && first_g1 < 0) first_g1 = i;
      step(1, 1, 1, 1, 32'h30, 32'h34, 32'h5 + i, 32'h6 + i);
    end
    check_eq("burst_ack0_cnt", 64'(n_ack0), 64'd4);
    check_eq("burst_gnt1_cycle", 64'(first_g1), 64'd4);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic against the model.
    do_reset();
    r0 = 0;
    r1 = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) r0 = ~r0;
      if ($urandom_range(0, 3) == 0) r1 = ~r1;
      step(r0, r1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           AW'({$urandom_range(0, 15), 2'b00}), AW'({$urandom_range(0, 15), 2'b00}),
           $urandom, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
